// File: rtl/sigmoid_backward.sv
// sigmoid_backward: multi-cycle backward pass of the sigmoid activation.
// Computes out_grad = g * s * (1 - s) in IEEE 754 single precision. It uses one
// shared adder/subtractor and one shared multiplier, sequenced by a small FSM.
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   in_valid/in_ready      operand handshake (in_sig = s, in_grad = g, round_mode)
//   out_valid/out_ready    result handshake (out_grad, exceptions)
//   round_mode             3'd0 RNE, 3'd1 RTZ, 3'd2 RDN, 3'd3 RUP, 3'd4 RMM
//                          (codes 5..7 behave as RNE)
//   exceptions             {invalid, div_by_zero, overflow, underflow, inexact}
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE. out_valid is high only in DONE.
// While out_valid is high, out_grad and exceptions hold until out_ready.

// Normalize, round and pack one result. The value represented is
// mant * 2^(exp - 127), with the binary point just below mant[51].
module fp_round_pack (
  input  logic               sign,
  input  logic signed [11:0] exp,
  input  logic [51:0]        mant,
  input  logic [2:0]         rm,
  output logic [31:0]        result,
  output logic [4:0]         flags
);
  logic [5:0]         lz;
  logic               found;
  logic [51:0]        norm, den, lost_mask;
  logic signed [11:0] e;
  logic [11:0]        rsh;
  logic [23:0]        m;
  logic               gd, st, inc, tiny, inexact, to_max;
  logic [24:0]        mr;

  always_comb begin
    lz    = 6'd0;
    found = 1'b0;
    for (int i = 51; i >= 0; i--) begin
      if (!found && mant[i]) found = 1'b1;
      else if (!found) lz = lz + 6'd1;
    end
    norm      = mant << lz;
    e         = exp - $signed({6'b0, lz});
    // Tininess is detected before rounding.
    tiny      = (e < 12'sd1);
    rsh       = 12'd0;
    den       = norm;
    lost_mask = '0;
    if (tiny) begin
      // Denormalize so the exponent field reads as the minimum. Shifted-out
      // bits fold into bit 0 to act as sticky.
      rsh = $unsigned(12'sd1 - e);
      if (rsh >= 12'd52) begin
        den = {51'b0, |norm};
      end else begin
        lost_mask = ~({52{1'b1}} << rsh);
        den = (norm >> rsh) | {51'b0, |(norm & lost_mask)};
      end
      e = 12'sd1;
    end
    m       = den[51:28];
    gd      = den[27];
    st      = |den[26:0];
    inexact = gd | st;
    case (rm)
      3'd1:    inc = 1'b0;
      3'd2:    inc = inexact & sign;
      3'd3:    inc = inexact & ~sign;
      3'd4:    inc = gd;
      default: inc = gd & (st | m[0]);
    endcase
    mr = {1'b0, m} + {24'b0, inc};
    if (mr[24]) begin
      mr = {1'b0, mr[24:1]};
      e  = e + 12'sd1;
    end
    // Modes that round toward zero on this side saturate to max finite.
    to_max = (rm == 3'd1) || (rm == 3'd2 && !sign) || (rm == 3'd3 && sign);
    if (mant == 52'd0) begin
      result = {sign, 31'b0};
      flags  = 5'b0;
    end else if (e >= 12'sd255) begin
      result = to_max ? {sign, 8'hfe, 23'h7fffff} : {sign, 8'hff, 23'h0};
      flags  = 5'b00101;
    end else begin
      // A denormal that rounds up into bit 23 becomes the minimum normal.
      result = {sign, mr[23] ? e[7:0] : 8'h00, mr[22:0]};
      flags  = {3'b000, tiny & inexact, inexact};
    end
  end
endmodule

// Single precision adder/subtractor. op = 1 computes a - b.
module fp_add_sub (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        op,
  input  logic [2:0]  rm,
  output logic [31:0] result,
  output logic [4:0]  flags
);
  logic               sa, sb, sbig, ssml, swap, sub;
  logic [7:0]         eea, eeb, ebig, diff;
  logic [23:0]        ma, mb, mbig, msml;
  logic [51:0]        xb, xs, xsh, sum, lmask;
  logic               nan_a, nan_b, snan_a, snan_b, inf_a, inf_b;
  logic               rsign;
  logic signed [11:0] rexp;
  logic [31:0]        r_res;
  logic [4:0]         r_flags;

  always_comb begin
    sa     = a[31];
    sb     = b[31] ^ op;
    nan_a  = (a[30:23] == 8'hff) && (a[22:0] != 23'd0);
    nan_b  = (b[30:23] == 8'hff) && (b[22:0] != 23'd0);
    snan_a = nan_a && !a[22];
    snan_b = nan_b && !b[22];
    inf_a  = (a[30:23] == 8'hff) && (a[22:0] == 23'd0);
    inf_b  = (b[30:23] == 8'hff) && (b[22:0] == 23'd0);
    ma     = {a[30:23] != 8'd0, a[22:0]};
    mb     = {b[30:23] != 8'd0, b[22:0]};
    eea    = (a[30:23] == 8'd0) ? 8'd1 : a[30:23];
    eeb    = (b[30:23] == 8'd0) ? 8'd1 : b[30:23];
    swap   = {eea, ma} < {eeb, mb};
    sbig   = swap ? sb : sa;
    ssml   = swap ? sa : sb;
    ebig   = swap ? eeb : eea;
    mbig   = swap ? mb : ma;
    msml   = swap ? ma : mb;
    diff   = swap ? (eeb - eea) : (eea - eeb);
    // Bit 51 is headroom for the carry out of an addition.
    xb     = {1'b0, mbig, 27'b0};
    xs     = {1'b0, msml, 27'b0};
    lmask  = '0;
    if (diff >= 8'd52) begin
      xsh = {51'b0, |msml};
    end else begin
      lmask = ~({52{1'b1}} << diff);
      xsh   = (xs >> diff) | {51'b0, |(xs & lmask)};
    end
    sub  = sbig ^ ssml;
    sum  = sub ? (xb - xsh) : (xb + xsh);
    rexp = $signed({4'b0, ebig}) + 12'sd1;
    // Exact zero: +0 unless both operands are negative or rounding down.
    if (sum == 52'd0) rsign = (sbig & ssml) | (sub & (rm == 3'd2));
    else              rsign = sbig;
  end

  fp_round_pack u_round (
    .sign   (rsign),
    .exp    (rexp),
    .mant   (sum),
    .rm     (rm),
    .result (r_res),
    .flags  (r_flags)
  );

  always_comb begin
    if (nan_a || nan_b) begin
      result = 32'h7fc00000;
      flags  = {snan_a | snan_b, 4'b0};
    end else if (inf_a && inf_b && (sa != sb)) begin
      result = 32'h7fc00000;
      flags  = 5'b10000;
    end else if (inf_a) begin
      result = {sa, 8'hff, 23'h0};
      flags  = 5'b0;
    end else if (inf_b) begin
      result = {sb, 8'hff, 23'h0};
      flags  = 5'b0;
    end else begin
      result = r_res;
      flags  = r_flags;
    end
  end
endmodule

// Single precision multiplier.
module fp_mul (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  rm,
  output logic [31:0] result,
  output logic [4:0]  flags
);
  logic               rsign;
  logic [7:0]         eea, eeb;
  logic [23:0]        ma, mb;
  logic [47:0]        prod;
  logic signed [11:0] rexp;
  logic               nan_a, nan_b, snan_a, snan_b, inf_a, inf_b, zero_a, zero_b;
  logic [31:0]        r_res;
  logic [4:0]         r_flags;

  always_comb begin
    rsign  = a[31] ^ b[31];
    nan_a  = (a[30:23] == 8'hff) && (a[22:0] != 23'd0);
    nan_b  = (b[30:23] == 8'hff) && (b[22:0] != 23'd0);
    snan_a = nan_a && !a[22];
    snan_b = nan_b && !b[22];
    inf_a  = (a[30:23] == 8'hff) && (a[22:0] == 23'd0);
    inf_b  = (b[30:23] == 8'hff) && (b[22:0] == 23'd0);
    zero_a = (a[30:0] == 31'd0);
    zero_b = (b[30:0] == 31'd0);
    ma     = {a[30:23] != 8'd0, a[22:0]};
    mb     = {b[30:23] != 8'd0, b[22:0]};
    eea    = (a[30:23] == 8'd0) ? 8'd1 : a[30:23];
    eeb    = (b[30:23] == 8'd0) ? 8'd1 : b[30:23];
    prod   = 48'(ma) * 48'(mb);
    // prod[47] carries weight 2^1, so the exponent gets one extra step.
    rexp   = $signed({4'b0, eea}) + $signed({4'b0, eeb}) - 12'sd126;
  end

  fp_round_pack u_round (
    .sign   (rsign),
    .exp    (rexp),
    .mant   ({prod, 4'b0}),
    .rm     (rm),
    .result (r_res),
    .flags  (r_flags)
  );

  always_comb begin
    if (nan_a || nan_b) begin
      result = 32'h7fc00000;
      flags  = {snan_a | snan_b, 4'b0};
    end else if ((inf_a && zero_b) || (zero_a && inf_b)) begin
      result = 32'h7fc00000;
      flags  = 5'b10000;
    end else if (inf_a || inf_b) begin
      result = {rsign, 8'hff, 23'h0};
      flags  = 5'b0;
    end else begin
      result = r_res;
      flags  = r_flags;
    end
  end
endmodule

module sigmoid_backward (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_sig,
  input  logic [31:0] in_grad,
  input  logic [2:0]  round_mode,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_grad,
  output logic [4:0]  exceptions
);
  typedef enum logic [2:0] {IDLE, SUB, MUL1, MUL2, DONE} state_t;

  state_t      state;
  logic [31:0] s_reg, g_reg, d_reg, p_reg;
  logic [2:0]  rm_reg;
  logic [31:0] add_res, mul_res, mul_a, mul_b;
  logic [4:0]  add_flags, mul_flags;

  // Operands come only from captured registers, so input changes after
  // accept cannot disturb the operation in flight.
  assign mul_a = (state == MUL2) ? p_reg : s_reg;
  assign mul_b = (state == MUL2) ? g_reg : d_reg;

  fp_add_sub u_add_sub (
    .a      (32'h3f800000),
    .b      (s_reg),
    .op     (1'b1),
    .rm     (rm_reg),
    .result (add_res),
    .flags  (add_flags)
  );

  fp_mul u_mul (
    .a      (mul_a),
    .b      (mul_b),
    .rm     (rm_reg),
    .result (mul_res),
    .flags  (mul_flags)
  );

  // exceptions doubles as the sticky flag register for the operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_grad   <= 32'h0;
      exceptions <= 5'b0;
      s_reg      <= 32'h0;
      g_reg      <= 32'h0;
      d_reg      <= 32'h0;
      p_reg      <= 32'h0;
      rm_reg     <= 3'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            s_reg      <= in_sig;
            g_reg      <= in_grad;
            rm_reg     <= round_mode;
            exceptions <= 5'b0;
            in_ready   <= 1'b0;
            state      <= SUB;
          end
        end
        SUB: begin
          d_reg      <= add_res;
          exceptions <= exceptions | add_flags;
          state      <= MUL1;
        end
        MUL1: begin
          p_reg      <= mul_res;
          exceptions <= exceptions | mul_flags;
          state      <= MUL2;
        end
        MUL2: begin
          out_grad   <= mul_res;
          exceptions <= exceptions | mul_flags;
          out_valid  <= 1'b1;
          state      <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sigmoid_backward.sv
// Testbench for sigmoid_backward: directed cases, backpressure, reset
// mid-operation, NaN inputs, and randomized operands checked against a
// real-arithmetic reference model.
module tb_sigmoid_backward;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_sig;
  logic [31:0] in_grad;
  logic [2:0]  round_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_grad;
  logic [4:0]  exceptions;

  int errors = 0;
  int checks = 0;
  logic [36:0] exp_q[$];  // {exceptions, out_grad}

  sigmoid_backward dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sig     (in_sig),
    .in_grad    (in_grad),
    .round_mode (round_mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_grad   (out_grad),
    .exceptions (exceptions)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [36:0] obs, input logic [36:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // reference model: exact real arithmetic, then rounding to single
  function automatic real to_real(input logic [31:0] x);
    logic [10:0] e11;
    if (x[30:0] == 31'd0) return 0.0;
    e11 = {3'b0, x[30:23]} + 11'd896;
    return $bitstoreal({x[31], e11, x[22:0], 29'd0});
  endfunction

  // Returns {inexact, single}. Valid for values in the normal single range.
  function automatic logic [32:0] to_single(input real v, input logic [2:0] rm);
    logic [63:0] b;
    int          e;
    logic [23:0] m;
    logic        gd, st, inc;
    logic [24:0] mm;
    b = $realtobits(v);
    if (b[62:0] == 63'd0) return {1'b0, b[63], 31'd0};
    e  = int'(b[62:52]) - 896;
    m  = {1'b1, b[51:29]};
    gd = b[28];
    st = |b[27:0];
    case (rm)
      3'd1:    inc = 1'b0;
      3'd2:    inc = (gd | st) & b[63];
      3'd3:    inc = (gd | st) & ~b[63];
      3'd4:    inc = gd;
      default: inc = gd & (st | m[0]);
    endcase
    mm = {1'b0, m} + {24'd0, inc};
    if (mm[24]) begin
      mm = mm >> 1;
      e  = e + 1;
    end
    return {gd | st, b[63], 8'(e), mm[22:0]};
  endfunction

  // driver: one full operation, result checked against the head of exp_q
  task automatic do_op(input logic [31:0] s, input logic [31:0] g, input logic [2:0] rm,
                       input int hold, input bit nan_mode);
    logic [36:0] e;
    int cnt;
    cnt = 0;
    while (!in_ready && cnt < 20) begin
      tick();
      cnt++;
    end
    chk("in_ready_idle", 37'(in_ready), 37'd1);
    in_sig     = s;
    in_grad    = g;
    round_mode = rm;
    in_valid   = 1'b1;
    tick();
    in_valid   = 1'b0;
    // Inputs changing after accept must not affect the result.
    in_sig     = $urandom;
    in_grad    = $urandom;
    round_mode = 3'($urandom_range(4, 0));
    cnt = 0;
    while (!out_valid && cnt < 10) begin
      tick();
      cnt++;
    end
    chk("latency", 37'(cnt), 37'd3);
    e = exp_q.pop_front();
    if (nan_mode) begin
      chk("nan_exponent", 37'(out_grad[30:23]), 37'h0ff);
      chk("nan_mantissa_nonzero", 37'(|out_grad[22:0]), 37'd1);
    end else begin
      chk("out_grad", 37'(out_grad), 37'(e[31:0]));
    end
    chk("exceptions", 37'(exceptions), 37'(e[36:32]));
    for (int k = 0; k < hold; k++) begin
      if (k == 2) begin
        in_valid = 1'b1;
        in_sig   = 32'h3e800000;
        in_grad  = 32'h40400000;
      end
      tick();
      in_valid = 1'b0;
      chk("bp_out_valid", 37'(out_valid), 37'd1);
      chk("bp_in_ready", 37'(in_ready), 37'd0);
      chk("bp_out_grad", 37'(out_grad), 37'(e[31:0]));
      chk("bp_exceptions", 37'(exceptions), 37'(e[36:32]));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("handoff_out_valid", 37'(out_valid), 37'd0);
    chk("handoff_in_ready", 37'(in_ready), 37'd1);
  endtask

  initial begin
    logic [31:0] s, g;
    logic [2:0]  rm;
    logic [32:0] t1, t2, t3;

    rst        = 1'b1;
    in_valid   = 1'b0;
    in_sig     = 32'h0;
    in_grad    = 32'h0;
    round_mode = 3'd0;
    out_ready  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_out_valid", 37'(out_valid), 37'd0);
    chk("reset_in_ready", 37'(in_ready), 37'd1);
    chk("reset_out_grad", 37'(out_grad), 37'd0);
    chk("reset_exceptions", 37'(exceptions), 37'd0);

    // directed values
    exp_q.push_back({5'b0, 32'h3e800000});
    do_op(32'h3f000000, 32'h3f800000, 3'd0, 0, 0);
    exp_q.push_back({5'b0, 32'h3ec00000});
    do_op(32'h3f400000, 32'h40000000, 3'd0, 0, 0);
    exp_q.push_back({5'b0, 32'h00000000});
    do_op(32'h3f800000, 32'h42c80000, 3'd0, 0, 0);
    exp_q.push_back({5'b0, 32'hbf800000});
    do_op(32'h3f000000, 32'hc0800000, 3'd0, 0, 0);

    // backpressure, then a second pair completes normally
    exp_q.push_back({5'b0, 32'h3ec00000});
    do_op(32'h3f400000, 32'h40000000, 3'd0, 6, 0);
    exp_q.push_back({5'b0, 32'hbf800000});
    do_op(32'h3f000000, 32'hc0800000, 3'd0, 0, 0);

    // reset while in MUL1 discards the operation
    in_sig   = 32'h3f400000;
    in_grad  = 32'h40000000;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_out_valid", 37'(out_valid), 37'd0);
    chk("midrst_in_ready", 37'(in_ready), 37'd1);
    chk("midrst_out_grad", 37'(out_grad), 37'd0);
    chk("midrst_exceptions", 37'(exceptions), 37'd0);
    tick();
    tick();
    tick();
    chk("midrst_discarded", 37'(out_valid), 37'd0);
    exp_q.push_back({5'b0, 32'h3e800000});
    do_op(32'h3f000000, 32'h3f800000, 3'd0, 0, 0);

    // quiet NaN passes through silently; signaling NaN raises invalid
    exp_q.push_back({5'b0, 32'h7fc00000});
    do_op(32'h7fc00000, 32'h3f800000, 3'd0, 0, 1);
    exp_q.push_back({5'b10000, 32'h7fc00000});
    do_op(32'h7f800001, 32'h3f800000, 3'd0, 0, 1);
    // sticky flags from the previous operation are cleared on accept
    exp_q.push_back({5'b0, 32'h3e800000});
    do_op(32'h3f000000, 32'h3f800000, 3'd0, 0, 0);

    // randomized operands against the reference model
    for (int i = 0; i < 40; i++) begin
      s  = {1'b0, 8'($urandom_range(126, 120)), 23'($urandom)};
      g  = {1'($urandom_range(1, 0)), 8'($urandom_range(150, 100)), 23'($urandom)};
      rm = 3'($urandom_range(4, 0));
      t1 = to_single(1.0 - to_real(s), rm);
      t2 = to_single(to_real(s) * to_real(t1[31:0]), rm);
      t3 = to_single(to_real(t2[31:0]) * to_real(g), rm);
      exp_q.push_back({4'b0, t1[32] | t2[32] | t3[32], t3[31:0]});
      do_op(s, g, rm, (i % 10 == 9) ? 3 : 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
